io_input: RTL and testbench
===========================

IO_INPUT -- requirements
Module: io_input

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of the bus read data.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, stable-sample count before a debounced bit changes; range 2..65535.
REQ-003 Parameter BASE_ADDR, default 16'h3FF0, first word of the 4-word IO input window.
REQ-004 clk  input  1  system clock; all state on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 switches  input  10  raw slide switches, asynchronous, active-high.
REQ-007 keys  input  4  raw pushbuttons, asynchronous, active-low (pressed = 0).
REQ-008 addr  input  16  bus address, same address space as the data memory.
REQ-009 re  input  1  read strobe, qualified by addr.
REQ-010 dataOut  output  DATA_WIDTH  read data, valid one cycle after an accepted read.
REQ-011 hit  output  1  high in the cycle dataOut carries IO data; datapath muxes dataOut over memory data.
REQ-012 irq  output  1  high while any press flag is set.

Function
REQ-013 Each switch and key bit shall pass through a 2-flop synchronizer before any other logic.
REQ-014 Each synchronized bit shall be debounced: debounced value changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch break restarts the count at 0.
REQ-015 Key levels shall be inverted after debouncing so pressed = 1 internally.
REQ-016 A press event shall be a 0->1 transition of a debounced key level; it sets that key's sticky press flag the cycle after the transition.
REQ-017 Register map (word offset from BASE_ADDR): 0 = SW {6'b0, sw[9:0]}; 1 = KEYLVL {12'b0, level[3:0]}; 2 = KEYFLAG {12'b0, flag[3:0]}; 3 = ID 16'hA10F.
REQ-018 A read is accepted when re=1 and addr is in [BASE_ADDR, BASE_ADDR+3]; dataOut and hit shall be registered with exactly 1-cycle latency.
REQ-019 Without an accepted read, hit shall be 0 next cycle and dataOut shall hold its last value.
REQ-020 An accepted read of KEYFLAG shall return the flags as they are that cycle and clear them on the same edge (clear-on-read).
REQ-021 A press event on the same edge as a KEYFLAG clear shall leave that flag set; the returned data shows the pre-event value.
REQ-022 Back-to-back reads on consecutive cycles shall each be accepted; a second KEYFLAG read returns only events after the first.
REQ-023 Addresses outside the window shall be ignored; no side effects.
REQ-024 irq shall equal OR of flag[3:0], registered, no extra delay beyond the flag register.

Reset
REQ-025 reset shall asynchronously force: synchronizer flops, debounced switches, and counters to 0; debounced raw keys to 1 (released); flags to 0.
REQ-026 On reset: dataOut = 0, hit = 0, irq = 0.
REQ-027 Reset asserted mid-debounce shall discard the partial count; no press event shall be generated by the reset release itself.

Structure
REQ-028 Register offsets, ID value and register widths shall live in the shared IO package/header used by all memory-mapped peripherals.
REQ-029 One sub-module, io_debounce (synchronizer + counter for one bit, reset value parameterized), shall be instantiated 14 times.
REQ-030 Counter width shall be 16 bits; no arithmetic wider than 16 bits.

Verification
(bench uses DEBOUNCE_CYCLES = 4)
REQ-031 Reset, then read offsets 0..3 -> 16'h0000, 16'h0000, 16'h0000, 16'hA10F, each with hit=1 one cycle after re; irq=0.
REQ-032 switches = 10'h2A5 held stable -> SW read returns 16'h02A5 no earlier than 2+4 cycles after change; a 3-cycle glitch to 10'h000 -> SW unchanged.
REQ-033 keys[2] low for 10 cycles then high -> KEYLVL shows 16'h0004 while held; irq=1; KEYFLAG read returns 16'h0004; next KEYFLAG read returns 16'h0000; irq=0.
REQ-034 keys[0] press event lands on the same edge as a KEYFLAG read -> that read returns 16'h0000, next read returns 16'h0001.
REQ-035 re=1 with addr = 16'h3FEF and 16'h3FF4 -> hit=0, flags unchanged.
REQ-036 reset pulsed while keys[1] held low 2 cycles into debounce -> after release of reset and key, flag[1] = 0 and no irq.

Source files
------------

// File: rtl/io_input_pkg.sv
// Shared register map for the memory-mapped IO input peripheral.
// Offsets, ID word and register widths live here so every peripheral decodes the same way.
package io_input_pkg;

    localparam int unsigned IO_REG_W        = 16;
    localparam int unsigned IO_SW_W         = 10;
    localparam int unsigned IO_KEY_W        = 4;
    localparam int unsigned IO_WINDOW_WORDS = 4;
    localparam logic [IO_REG_W-1:0] IO_ID_VALUE = 16'hA10F;

    typedef enum logic [1:0] {
        IO_REG_SW      = 2'd0,
        IO_REG_KEYLVL  = 2'd1,
        IO_REG_KEYFLAG = 2'd2,
        IO_REG_ID      = 2'd3
    } io_reg_e;

    function automatic logic [IO_REG_W-1:0] io_reg_word(
        input io_reg_e             sel,
        input logic [IO_SW_W-1:0]  sw,
        input logic [IO_KEY_W-1:0] lvl,
        input logic [IO_KEY_W-1:0] flag
    );
        logic [IO_REG_W-1:0] w;
        w = '0;
        case (sel)
            IO_REG_SW:      w[IO_SW_W-1:0]  = sw;
            IO_REG_KEYLVL:  w[IO_KEY_W-1:0] = lvl;
            IO_REG_KEYFLAG: w[IO_KEY_W-1:0] = flag;
            IO_REG_ID:      w               = IO_ID_VALUE;
            default:        w               = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/io_input_debounce.sv
// One-bit 2-flop synchronizer followed by a consecutive-mismatch debounce counter.
module io_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        sync1_q, sync2_q;
    logic [1:0]  prime_q;
    logic        deb_q, deb_d;
    logic [15:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prime_q <= '0;
            cnt_q   <= '0;
            deb_q   <= RESET_VAL;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            prime_q <= {prime_q[0], 1'b1};
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
        end
    end

    // Counting waits until the synchronizer holds real samples, so the reset-cleared
    // flops cannot be mistaken for a press on a key whose output resets to released.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (prime_q[1] && (sync2_q != deb_q)) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    assign dout = deb_q;

endmodule

// File: rtl/io_input.sv
// Memory-mapped switch/key input block: debounced levels, sticky clear-on-read press flags,
// and a 4-word read window with single-cycle registered read data.
module io_input
    import io_input_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic [15:0] BASE_ADDR       = 16'h3FF0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IO_SW_W-1:0]    switches,
    input  logic [IO_KEY_W-1:0]   keys,
    input  logic [15:0]           addr,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  hit,
    output logic                  irq
);

    localparam int unsigned NBITS = IO_SW_W + IO_KEY_W;

    logic [NBITS-1:0]      raw, deb;
    logic [IO_SW_W-1:0]    sw;
    logic [IO_KEY_W-1:0]   lvl, lvl_prev_q, press;
    logic [IO_KEY_W-1:0]   flag_q, flag_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  hit_q, hit_d;
    logic [15:0]           offset;
    logic                  rd_acc;
    io_reg_e               reg_sel;

    assign raw = {keys, switches};

    for (genvar i = 0; i < NBITS; i++) begin : g_deb
        io_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VAL      (i >= IO_SW_W)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .din  (raw[i]),
            .dout (deb[i])
        );
    end

    assign sw    = deb[IO_SW_W-1:0];
    assign lvl   = ~deb[NBITS-1:IO_SW_W];
    assign press = lvl & ~lvl_prev_q;

    // Wrapping subtraction keeps the window test within 16 bits even near the top of memory.
    assign offset  = addr - BASE_ADDR;
    assign rd_acc  = re && (offset < 16'(IO_WINDOW_WORDS));
    assign reg_sel = io_reg_e'(offset[1:0]);

    always_comb begin
        flag_d = flag_q;
        data_d = data_q;
        hit_d  = 1'b0;
        if (rd_acc) begin
            hit_d  = 1'b1;
            data_d = DATA_WIDTH'(io_reg_word(reg_sel, sw, lvl, flag_q));
            if (reg_sel == IO_REG_KEYFLAG) begin
                flag_d = '0;
            end
        end
        flag_d = flag_d | press;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_prev_q <= '0;
            flag_q     <= '0;
            data_q     <= '0;
            hit_q      <= 1'b0;
        end else begin
            lvl_prev_q <= lvl;
            flag_q     <= flag_d;
            data_q     <= data_d;
            hit_q      <= hit_d;
        end
    end

    assign dataOut = data_q;
    assign hit     = hit_q;
    assign irq     = |flag_q;

endmodule

// File: tb/tb_io_input.sv
// Randomized and directed bench for io_input against a queue-based behavioural model.
module tb_io_input;

    localparam int unsigned DW   = 16;
    localparam int unsigned DB   = 4;
    localparam logic [15:0] BASE = 16'h3FF0;

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    switches;
    logic [3:0]    keys;
    logic [15:0]   addr;
    logic          re;
    logic [DW-1:0] dataOut;
    logic          hit;
    logic          irq;

    int checks = 0;
    int errors = 0;

    io_input #(
        .DATA_WIDTH     (DW),
        .DEBOUNCE_CYCLES(DB),
        .BASE_ADDR      (BASE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .switches(switches),
        .keys    (keys),
        .addr    (addr),
        .re      (re),
        .dataOut (dataOut),
        .hit     (hit),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: raw samples since reset, per-bit mismatch run lengths.
    logic [13:0] m_deb;
    int          m_run [14];
    logic [13:0] m_hist [$];
    logic [3:0]  m_flag;
    logic [3:0]  m_rose;
    logic [15:0] m_data;
    logic        m_hit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_deb = {4'hF, 10'h000};
        foreach (m_run[i]) m_run[i] = 0;
        m_hist.delete();
        m_flag = '0;
        m_rose = '0;
        m_data = '0;
        m_hit  = 1'b0;
    endtask

    task automatic model_step();
        logic [15:0] off;
        logic [13:0] seen;
        logic [3:0]  lvl_old;
        off     = addr - BASE;
        lvl_old = ~m_deb[13:10];
        m_hit   = re && (off < 16'd4);
        if (m_hit) begin
            case (off[1:0])
                2'd0:    m_data = {6'b0, m_deb[9:0]};
                2'd1:    m_data = {12'b0, lvl_old};
                2'd2:    m_data = {12'b0, m_flag};
                default: m_data = 16'hA10F;
            endcase
        end
        m_flag = ((m_hit && off == 16'd2) ? 4'b0 : m_flag) | m_rose;
        m_hist.push_back({keys, switches});
        if (m_hist.size() > 3) void'(m_hist.pop_front());
        if (m_hist.size() == 3) begin
            seen = m_hist[0];
            for (int b = 0; b < 14; b++) begin
                if (seen[b] != m_deb[b]) begin
                    m_run[b]++;
                    if (m_run[b] == int'(DB)) begin
                        m_deb[b] = seen[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
        m_rose = ~m_deb[13:10] & ~lvl_old;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
        check("hit", 32'(hit), 32'(m_hit));
        check("irq", 32'(irq), 32'(|m_flag));
        check("dataOut", 32'(dataOut), 32'(m_data));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        addr = a;
        re   = 1'b1;
        tick();
        re   = 1'b0;
        addr = 16'h0000;
        d    = dataOut;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic [15:0] rst_exp [4];
        rst_exp = '{16'h0000, 16'h0000, 16'h0000, 16'hA10F};

        reset = 1'b1; switches = '0; keys = 4'hF; addr = '0; re = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_dataOut", 32'(dataOut), 32'h0);
        check("rst_hit", 32'(hit), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            rd(BASE + 16'(i), d);
            check($sformatf("rst_off%0d", i), 32'(d), 32'(rst_exp[i]));
            check($sformatf("rst_hit%0d", i), 32'(hit), 32'h1);
        end
        check("rst_irq_after", 32'(irq), 32'h0);

        switches = 10'h2A5;
        idle(2);
        rd(BASE, d);
        check("sw_early", 32'(d), 32'h0000);
        idle(8);
        rd(BASE, d);
        check("sw_settled", 32'(d), 32'h02A5);
        switches = 10'h000;
        idle(3);
        switches = 10'h2A5;
        idle(10);
        rd(BASE, d);
        check("sw_glitch", 32'(d), 32'h02A5);

        keys = 4'b1011;
        idle(10);
        rd(BASE + 16'd1, d);
        check("key2_lvl", 32'(d), 32'h0004);
        check("key2_irq", 32'(irq), 32'h1);
        keys = 4'hF;
        idle(10);
        rd(BASE + 16'd2, d);
        check("key2_flag", 32'(d), 32'h0004);
        rd(BASE + 16'd2, d);
        check("key2_flag_clr", 32'(d), 32'h0000);
        check("key2_irq_clr", 32'(irq), 32'h0);

        // Press edge on keys[0] lands on the seventh rising edge after the change.
        keys = 4'b1110;
        idle(6);
        rd(BASE + 16'd2, d);
        check("key0_coincide", 32'(d), 32'h0000);
        rd(16'h3FEF, d);
        check("oow_lo_hit", 32'(hit), 32'h0);
        check("oow_lo_irq", 32'(irq), 32'h1);
        rd(16'h3FF4, d);
        check("oow_hi_hit", 32'(hit), 32'h0);
        rd(BASE + 16'd2, d);
        check("key0_after", 32'(d), 32'h0001);
        keys = 4'hF;
        idle(10);

        keys = 4'b1101;
        idle(2);
        reset = 1'b1;
        model_reset();
        keys = 4'hF;
        idle(2);
        reset = 1'b0;
        idle(12);
        check("rst_mid_irq", 32'(irq), 32'h0);
        rd(BASE + 16'd2, d);
        check("rst_mid_flag", 32'(d), 32'h0000);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) == 0) switches = 10'($urandom);
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 11) == 0) keys[k] = ~keys[k];
            end
            re   = ($urandom_range(0, 2) == 0);
            addr = BASE - 16'd2 + 16'($urandom_range(0, 7));
            tick();
        end
        re = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
